// File: rtl/coincidence_window_pkg.sv
// Shared types for the coincidence window block: channel count, FSM states,
// channel pattern type and a multiplicity helper.
package coinc_pkg;

    localparam int N_CH = 4;

    typedef logic [N_CH-1:0] pattern_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    function automatic logic multi_hit(input pattern_t p);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < N_CH; i++) begin
            n = n + 32'(p[i]);
        end
        return (n >= 32'd2);
    endfunction

endpackage

// File: rtl/coincidence_window_if.sv
// Valid/ready record channel carrying the coincidence pattern downstream.
interface coincidence_window_if;
    import coinc_pkg::*;

    logic     valid;
    logic     ready;
    pattern_t pattern;

    modport master (output valid, output pattern, input ready);
    modport slave  (input valid, input pattern, output ready);

endinterface

// File: rtl/coincidence_window_chan_sync.sv
// One channel: 2-FF synchroniser, previous-value register and registered
// rising-edge pulse.
module chan_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic hit_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic hit_q;

    // synchronise the level and turn its rising edge into a one-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            hit_q   <= sync2_q & ~prev_q;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/coincidence_window.sv
// Coincidence window: groups channel hits into a programmable window and
// reports multi-channel windows. Optional counters under COINC_STATS_EN.
module coincidence_window
    import coinc_pkg::*;
#(
    parameter int WIN_W = 8,
    parameter int OVF_W = 16,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  pattern_t                channels_i,
    input  logic                    enable_i,
    input  logic [WIN_W-1:0]        window_len_i,
    output pattern_t                hit_pulse_o,
    output logic                    busy_o,
    coincidence_window_if.master    coinc,
    output logic [OVF_W-1:0]        overflow_cnt_o,
    output logic [N_CH*CNT_W-1:0]   singles_cnt_o,
    output logic [CNT_W-1:0]        coinc_cnt_o
);

    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    pattern_t         hit_s;
    logic [WIN_W-1:0] eff_len_s;
    logic             report_s;
    logic             load_s;
    logic             drop_s;

    state_t           state_q;
    logic             busy_q;
    pattern_t         pattern_q;
    logic [WIN_W-1:0] cnt_q;
    logic             valid_q;
    pattern_t         cpat_q;
    logic [OVF_W-1:0] ovf_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        chan_sync u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .async_i (channels_i[i]),
            .hit_o   (hit_s[i])
        );
    end

    assign eff_len_s = (window_len_i == '0) ? WIN_ONE : window_len_i;

    // dropping enable in REPORT suppresses the record just like in OPEN
    assign report_s = (state_q == REPORT) && enable_i && multi_hit(pattern_q);
    assign load_s   = report_s && (!valid_q || coinc.ready);
    assign drop_s   = report_s && valid_q && !coinc.ready;

    // window FSM with busy registered alongside the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            pattern_q <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && (|hit_s)) begin
                        pattern_q <= hit_s;
                        cnt_q     <= eff_len_s - WIN_ONE;
                        busy_q    <= 1'b1;
                        state_q   <= (eff_len_s > WIN_ONE) ? OPEN : REPORT;
                    end
                end
                OPEN: begin
                    if (!enable_i) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        pattern_q <= '0;
                    end else begin
                        pattern_q <= pattern_q | hit_s;
                        cnt_q     <= cnt_q - WIN_ONE;
                        if (cnt_q == WIN_ONE) begin
                            state_q <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    pattern_q <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    pattern_q <= '0;
                end
            endcase
        end
    end

    // single-entry output slot and saturating drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            cpat_q  <= '0;
            ovf_q   <= '0;
        end else begin
            if (load_s) begin
                valid_q <= 1'b1;
                cpat_q  <= pattern_q;
            end else if (valid_q && coinc.ready) begin
                valid_q <= 1'b0;
            end
            if (drop_s && (ovf_q != {OVF_W{1'b1}})) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    assign busy_o         = busy_q;
    assign hit_pulse_o    = hit_s;
    assign coinc.valid    = valid_q;
    assign coinc.pattern  = cpat_q;
    assign overflow_cnt_o = ovf_q;

`ifdef COINC_STATS_EN
    logic [CNT_W-1:0] singles_q [N_CH];
    logic [CNT_W-1:0] coinc_cnt_q;

    // wrapping per-channel hit and accepted-record counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                singles_q[i] <= '0;
            end
            coinc_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (hit_s[i]) begin
                    singles_q[i] <= singles_q[i] + CNT_W'(1);
                end
            end
            if (load_s) begin
                coinc_cnt_q <= coinc_cnt_q + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_pack
        assign singles_cnt_o[i*CNT_W +: CNT_W] = singles_q[i];
    end
    assign coinc_cnt_o = coinc_cnt_q;
`else
    assign singles_cnt_o = '0;
    assign coinc_cnt_o   = '0;
`endif

endmodule
